// File: rtl/manchester_pkg.sv
// Shared types and pair decoding for the Manchester stream decoder.
package manchester_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Chip-pair polarity: NORMAL maps "10"->1, IEEE (802.3) maps "10"->0
    localparam int unsigned POL_NORMAL = 0;
    localparam int unsigned POL_IEEE   = 1;

    // Returns {valid, bit}; a pair is valid only when its two chips differ
    function automatic logic [1:0] pair_decode(input logic first,
                                               input logic second,
                                               input logic pol);
        pair_decode = {first ^ second, pol ? second : first};
    endfunction

endpackage

// File: rtl/manchester_out_reg.sv
// One-entry valid/ready holding register; a load while a word is stalled is dropped and flagged.
module manchester_out_reg #(
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          m_ready,
    output logic [DW-1:0] q_data,
    output logic          q_valid,
    output logic          overflow
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_data   <= '0;
            q_valid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (load) begin
                // Held word wins unless it is being consumed on this same edge
                if (q_valid && !m_ready) begin
                    overflow <= 1'b1;
                end else begin
                    q_data  <= load_data;
                    q_valid <= 1'b1;
                end
            end else if (q_valid && m_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/manchester_stream_dec.sv
// Streaming Manchester decoder: pair alignment, HUNT/LOCK tracking, MSB-first word packing.
// Define MANCH_ERR_CNT_EN to add the saturating err_cnt port counting invalid pairs in LOCK.
module manchester_stream_dec #(
    parameter int unsigned W         = 8,
    parameter int unsigned POL       = 0,
    parameter int unsigned SYNC_LEN  = 8,
    parameter int unsigned ERR_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         chip_in,
    input  logic         chip_vld,
    output logic [W-1:0] m_data,
    output logic         m_err,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         locked,
    output logic         overflow
`ifdef MANCH_ERR_CNT_EN
    ,
    output logic [15:0]  err_cnt
`endif
);

    import manchester_pkg::*;

    localparam int unsigned SW = (SYNC_LEN  > 1) ? $clog2(SYNC_LEN)  : 1;
    localparam int unsigned BW = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;
    localparam int unsigned CW = $clog2(W);

    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(ERR_LIMIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(W - 1);

    state_e        state;
    logic          phase;
    logic          first_chip;
    logic [SW-1:0] sync_cnt;
    logic [BW-1:0] bad_cnt;
    logic [CW-1:0] bit_cnt;
    logic [W-2:0]  shreg;
    logic          word_err;

    logic [1:0]    pair_c;
    logic          pair_evt_c;
    logic          pair_ok_c;
    logic          dbit_c;
    logic          limit_hit_c;
    logic          load_c;
    logic [W:0]    word_c;
    logic [W:0]    obuf;

    assign pair_c      = pair_decode(first_chip, chip_in, POL == POL_IEEE);
    assign pair_evt_c  = chip_vld & phase;
    assign pair_ok_c   = pair_c[1];
    assign dbit_c      = pair_c[1] & pair_c[0];
    assign limit_hit_c = ~pair_ok_c & (bad_cnt == BAD_LAST);
    // A word finishing on the pair that trips the error limit is never delivered
    assign load_c      = pair_evt_c & (state == LOCK) & (bit_cnt == BIT_LAST) & ~limit_hit_c;
    assign word_c      = {word_err | ~pair_ok_c, shreg, dbit_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            phase      <= 1'b0;
            first_chip <= 1'b0;
            sync_cnt   <= '0;
            bad_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            word_err   <= 1'b0;
        end else if (chip_vld) begin
            if (!phase) begin
                first_chip <= chip_in;
                phase      <= 1'b1;
            end else if (state == HUNT) begin
                if (pair_ok_c) begin
                    phase <= 1'b0;
                    if (sync_cnt == SYNC_LAST) begin
                        state    <= LOCK;
                        sync_cnt <= '0;
                        bit_cnt  <= '0;
                        bad_cnt  <= '0;
                        word_err <= 1'b0;
                    end else begin
                        sync_cnt <= sync_cnt + SW'(1);
                    end
                end else begin
                    // Slip by one chip: the second chip of the bad pair starts the next pair
                    first_chip <= chip_in;
                    sync_cnt   <= '0;
                end
            end else begin
                phase <= 1'b0;
                if (limit_hit_c) begin
                    state    <= HUNT;
                    sync_cnt <= '0;
                    bit_cnt  <= '0;
                    bad_cnt  <= '0;
                    word_err <= 1'b0;
                end else begin
                    shreg   <= word_c[W-2:0];
                    bad_cnt <= pair_ok_c ? '0 : bad_cnt + BW'(1);
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        word_err <= 1'b0;
                    end else begin
                        bit_cnt  <= bit_cnt + CW'(1);
                        word_err <= word_err | ~pair_ok_c;
                    end
                end
            end
        end
    end

    assign locked = (state == LOCK);

`ifdef MANCH_ERR_CNT_EN
    // Invalid pairs seen while locked, including the one that trips the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (pair_evt_c && (state == LOCK) && !pair_ok_c && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

    manchester_out_reg #(
        .DW (W + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .load_data (word_c),
        .m_ready   (m_ready),
        .q_data    (obuf),
        .q_valid   (m_valid),
        .overflow  (overflow)
    );

    assign m_data = obuf[W-1:0];
    assign m_err  = obuf[W];

endmodule

// File: tb/tb_manchester_stream_dec.sv
// Scoreboard bench for manchester_stream_dec (W=8, POL=0, SYNC_LEN=8, ERR_LIMIT=2).
// Also checks err_cnt when built with MANCH_ERR_CNT_EN.
module tb_manchester_stream_dec;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         chip_in;
    logic         chip_vld;
    logic [W-1:0] m_data;
    logic         m_err;
    logic         m_valid;
    logic         m_ready;
    logic         locked;
    logic         overflow;
`ifdef MANCH_ERR_CNT_EN
    logic [15:0]  err_cnt;
`endif

    logic [W:0] exp_q[$];
    int checks;
    int errors;
    int ovf_seen;

    manchester_stream_dec #(
        .W         (W),
        .POL       (0),
        .SYNC_LEN  (8),
        .ERR_LIMIT (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .chip_in  (chip_in),
        .chip_vld (chip_vld),
        .m_data   (m_data),
        .m_err    (m_err),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .locked   (locked),
        .overflow (overflow)
`ifdef MANCH_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chip(input logic b);
        chip_in  = b;
        chip_vld = 1'b1;
        @(posedge clk);
        #1;
        chip_vld = 1'b0;
    endtask

    task automatic pair(input logic a, input logic b);
        chip(a);
        chip(b);
    endtask

    // POL=0: bit 1 is sent as "10", bit 0 as "01"
    task automatic send_bit(input logic b);
        if (b) pair(1'b1, 1'b0);
        else   pair(1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic preamble();
        repeat (8) pair(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        chip_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_m_valid",  32'(m_valid),  32'd0);
        check("rst_locked",   32'(locked),   32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_m_data",   32'(m_data),   32'd0);
        check("rst_m_err",    32'(m_err),    32'd0);
`ifdef MANCH_ERR_CNT_EN
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
`endif
    endtask

    initial begin
        logic [W:0] exp_w;
        checks   = 0;
        errors   = 0;
        ovf_seen = 0;
        rst      = 1'b1;
        chip_in  = 1'b0;
        chip_vld = 1'b0;
        m_ready  = 1'b1;

        // Monitor: one transfer per cycle where valid&ready is seen between edges
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (overflow) ovf_seen++;
                    if (m_valid && m_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_word actual=%0h required=none", {m_err, m_data});
                        end else begin
                            exp_w = exp_q.pop_front();
                            check("word_data", 32'(m_data), 32'(exp_w[W-1:0]));
                            check("word_err",  32'(m_err),  32'(exp_w[W]));
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Aligned lock, then 0xA5
        preamble();
        check("t1_locked", 32'(locked), 32'd1);
        exp_q.push_back({1'b0, 8'hA5});
        send_word(8'hA5);
        check("t1_latency", 32'(m_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // One extra leading chip forces a slip before lock
        do_reset();
        chip(1'b1);
        preamble();
        check("t2_locked", 32'(locked), 32'd1);
        exp_q.push_back({1'b0, 8'hA5});
        send_word(8'hA5);
        repeat (3) @(posedge clk);
        #1;

        // "11" pair at bit 3 of 0xFF
        exp_q.push_back({1'b1, 8'hF7});
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 3) pair(1'b1, 1'b1);
            else        pair(1'b1, 1'b0);
        end
        check("t3_locked", 32'(locked), 32'd1);
`ifdef MANCH_ERR_CNT_EN
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
`endif
        repeat (3) @(posedge clk);
        #1;

        // Two consecutive "00" pairs mid-word drop lock, partial word discarded
        repeat (3) pair(1'b1, 1'b0);
        pair(1'b0, 1'b0);
        check("t4_still_locked", 32'(locked), 32'd1);
        pair(1'b0, 1'b0);
        check("t4_unlocked", 32'(locked), 32'd0);
`ifdef MANCH_ERR_CNT_EN
        check("t4_err_cnt", 32'(err_cnt), 32'd3);
`endif
        repeat (3) @(posedge clk);
        #1;

        // Word completing on the limit-hitting pair is discarded
        preamble();
        check("t4b_locked", 32'(locked), 32'd1);
        repeat (6) pair(1'b1, 1'b0);
        pair(1'b1, 1'b1);
        pair(1'b1, 1'b1);
        check("t4b_unlocked", 32'(locked), 32'd0);
        check("t4b_no_valid", 32'(m_valid), 32'd0);
`ifdef MANCH_ERR_CNT_EN
        check("t4b_err_cnt", 32'(err_cnt), 32'd5);
`endif

        // Backpressure: second word dropped, third loaded with no bubble
        preamble();
        m_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h3C});
        send_word(8'h3C);
        check("t5_valid_first", 32'(m_valid), 32'd1);
        send_word(8'hC3);
        check("t5_held_data",  32'(m_data),  32'h3C);
        check("t5_held_valid", 32'(m_valid), 32'd1);
        exp_q.push_back({1'b0, 8'h5A});
        for (int i = W - 1; i >= 1; i--) send_bit(W'(8'h5A) >> i & W'(1)) ;
        chip(1'b0);
        m_ready = 1'b1;
        chip(1'b1);
        check("t5_no_bubble", 32'(m_valid), 32'd1);
        check("t5_third_data", 32'(m_data), 32'h5A);
        repeat (3) @(posedge clk);
        #1;
        check("t5_overflow_count", 32'(ovf_seen), 32'd1);

        // Reset mid-word; a relock is needed before any output
        repeat (4) pair(1'b1, 1'b0);
        do_reset();
        send_word(8'hA5);
        check("t6_relocked", 32'(locked), 32'd1);
        check("t6_no_valid", 32'(m_valid), 32'd0);
        exp_q.push_back({1'b0, 8'h96});
        send_word(8'h96);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
